if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction-fetch stage that produces the `pc_4`/`inst`/`en` triple consumed by the IF/ID pipeline register. It is the producer end of that interface.
- Owns the PC and issues one-outstanding-request fetches to instruction memory over a req/gnt + rvalid handshake.
- Honours the same `load_use` stall and `jp_success` redirect that the IF/ID register sees.
- Sits between imem and IF/ID; the hazard unit drives its stall/redirect inputs.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- AW, 32, PC/address width; must be 32 for this core.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- load_use  in  1  stall: hold PC and presented instruction
- jp_success  in  1  redirect: flush in-flight fetch, restart at jp_target
- jp_target  in  32  redirect PC; bits [1:0] forced to 0 internally
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address (current PC)
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  read data valid
- imem_rdata  in  32  instruction word
- pc_4  out  32  PC+4 of delivered instruction
- inst  out  32  delivered instruction
- en  out  1  one-cycle strobe: IF/ID captures pc_4/inst

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values: pc=RESET_PC, state=REQ, imem_req=0 during reset, pc_4=0, inst=0, en=0, drop flag=0, hold valid=0.
- FSM states: REQ, WAIT, HOLD.
- REQ:
  - imem_req=1, imem_addr=pc.
  - On imem_gnt -> WAIT.
  - The request is held stable until granted.
- WAIT: imem_req=0. On imem_rvalid:
  - If drop=1: discard the data, clear drop, -> REQ. pc already holds the redirect target.
  - Else if load_use=0: en=1, inst=imem_rdata, pc_4=pc+4, pc<=pc+4, -> REQ.
  - Else (load_use=1): capture data into the hold buffer, en=0, -> HOLD.
- HOLD: en=0 while load_use=1. The first cycle with load_use=0 gives en=1, inst/pc_4 from the buffer, pc<=pc+4, -> REQ.
- en is combinational from state/inputs. pc_4 and inst stay registered and valid only when en=1; otherwise they hold their last value.
- Redirect (jp_success=1) has highest priority, over load_use and rvalid:
  - en=0, pc<=jp_target&~3, hold buffer cleared.
  - REQ without gnt: -> REQ with the new address next cycle.
  - REQ with gnt same cycle: -> WAIT, drop=1.
  - WAIT, rvalid not same cycle: stay WAIT, drop=1.
  - WAIT, rvalid same cycle: data discarded, -> REQ.
  - HOLD: -> REQ.
- A redirect while drop=1 keeps drop=1 and only updates pc.
- load_use in REQ does not block issuing the request; the stall applies only at delivery.
- Throughput: at most one instruction per 2 cycles (REQ+gnt, then WAIT+rvalid). Exactly one request is outstanding at any time.
- pc+4 wraps modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000); no exception is raised.
- Reset mid-operation: all state is cleared immediately. Any rvalid returning after reset release for a pre-reset request is ignored, because the FSM is in REQ and does not sample rvalid.

Decomposition:
- Shared package `pipeline_pkg`:
  - fetch state enum (REQ, WAIT, HOLD)
  - INST_NOP = 32'h0000_0000
  - default RESET_PC
  - PC_ALIGN_MASK = 32'hFFFF_FFFC
- No sub-module required. The hold buffer is ~10 lines and is kept inline.

Test Plan:
- Reset release, imem gnt on first cycle, rvalid next with rdata=32'h2008_0005 -> imem_addr=0; en pulses 1 cycle with inst=32'h2008_0005, pc_4=4; next request addr=4.
- rvalid arrives while load_use=1 for 3 cycles, rdata=32'hAC01_0000 -> en=0 for 3 cycles; en=1 on the cycle load_use drops with the same inst; next addr=pc+4.
- jp_success with jp_target=32'h0000_0103 in WAIT, rvalid 2 cycles later -> that response dropped, en stays 0; next imem_addr=32'h0000_0100.
- jp_success, load_use and rvalid all asserted in the same cycle -> en=0, data discarded; next cycle REQ at the aligned jp_target.
- pc=32'hFFFF_FFFC, delivery occurs -> pc_4=0; next imem_addr=0.
- rst_n asserted while in HOLD -> outputs immediately 0; after release, first imem_addr=RESET_PC; stale rvalid ignored.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Types and constants shared by the pipeline front-end blocks.
// Holds the fetch FSM encoding, the NOP word, and the PC reset and alignment constants.
package pipeline_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] INST_NOP         = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC and keeps one imem request outstanding.
// It presents pc_4/inst with a one-cycle en strobe for the IF/ID register.
module if_fetch_unit
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          AW       = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_use,
    input  logic          jp_success,
    input  logic [AW-1:0] jp_target,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_gnt,
    input  logic          imem_rvalid,
    input  logic [31:0]   imem_rdata,
    output logic [AW-1:0] pc_4,
    output logic [31:0]   inst,
    output logic          en
);

    fetch_state_e  r_state;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] r_pc_4;
    logic [31:0]   r_inst;
    logic          r_drop;
    logic          r_hold_valid;
    logic [31:0]   r_hold_data;

    fetch_state_e  w_state_nxt;
    logic [AW-1:0] w_pc_nxt;
    logic [AW-1:0] w_pc_plus4;
    logic          w_drop_nxt;
    logic          w_hold_valid_nxt;
    logic          w_hold_load;
    logic          w_en;
    logic [31:0]   w_deliver_inst;

    assign w_pc_plus4 = r_pc + AW'(4);

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_drop_nxt       = r_drop;
        w_hold_valid_nxt = r_hold_valid;
        w_hold_load      = 1'b0;
        w_en             = 1'b0;
        w_deliver_inst   = r_hold_data;

        if (jp_success) begin
            // The redirect wins over stall and delivery; a response already in flight must be dropped.
            w_pc_nxt         = align_pc(jp_target);
            w_hold_valid_nxt = 1'b0;
            case (r_state)
                REQ: begin
                    if (imem_gnt) begin
                        w_state_nxt = WAIT;
                        w_drop_nxt  = 1'b1;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        w_state_nxt = REQ;
                        w_drop_nxt  = 1'b0;
                    end else begin
                        w_drop_nxt  = 1'b1;
                    end
                end
                default: w_state_nxt = REQ;
            endcase
        end else begin
            case (r_state)
                REQ: begin
                    if (imem_gnt) w_state_nxt = WAIT;
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (r_drop) begin
                            w_drop_nxt  = 1'b0;
                            w_state_nxt = REQ;
                        end else if (!load_use) begin
                            w_en           = 1'b1;
                            w_deliver_inst = imem_rdata;
                            w_pc_nxt       = w_pc_plus4;
                            w_state_nxt    = REQ;
                        end else begin
                            w_hold_load      = 1'b1;
                            w_hold_valid_nxt = 1'b1;
                            w_state_nxt      = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!load_use && r_hold_valid) begin
                        w_en             = 1'b1;
                        w_deliver_inst   = r_hold_data;
                        w_pc_nxt         = w_pc_plus4;
                        w_hold_valid_nxt = 1'b0;
                        w_state_nxt      = REQ;
                    end
                end
                default: w_state_nxt = REQ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= REQ;
            r_pc         <= RESET_PC;
            r_pc_4       <= '0;
            r_inst       <= INST_NOP;
            r_drop       <= 1'b0;
            r_hold_valid <= 1'b0;
            r_hold_data  <= INST_NOP;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_drop       <= w_drop_nxt;
            r_hold_valid <= w_hold_valid_nxt;
            if (w_hold_load) r_hold_data <= imem_rdata;
            if (w_en) begin
                r_inst <= w_deliver_inst;
                r_pc_4 <= w_pc_plus4;
            end
        end
    end

    // Delivered values appear alongside en and are held afterwards; imem_req is low while reset is asserted.
    assign imem_req  = (r_state == REQ) && rst_n;
    assign imem_addr = r_pc;
    assign en        = w_en;
    assign inst      = w_en ? w_deliver_inst : r_inst;
    assign pc_4      = w_en ? w_pc_plus4 : r_pc_4;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: inputs change after the falling edge and outputs are checked 1 time unit later.
// The bench plays the role of imem, driving gnt and rvalid by hand.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        load_use;
    logic        jp_success;
    logic [31:0] jp_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pc_4;
    logic [31:0] inst;
    logic        en;

    int vectors;
    int miscompares;

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .AW(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_use   (load_use),
        .jp_success (jp_success),
        .jp_target  (jp_target),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .pc_4       (pc_4),
        .inst       (inst),
        .en         (en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic drive(input logic gnt, input logic rv, input logic [31:0] rd,
                         input logic lu, input logic jp, input logic [31:0] tgt);
        imem_gnt    = gnt;
        imem_rvalid = rv;
        imem_rdata  = rd;
        load_use    = lu;
        jp_success  = jp;
        jp_target   = tgt;
        #1;
    endtask

    task automatic next_cycle;
        @(negedge clk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        drive(0, 0, 32'h0, 0, 0, 32'h0);

        check("rst_req",  {31'b0, imem_req}, 32'h0);
        check("rst_en",   {31'b0, en},       32'h0);
        check("rst_inst", inst,              32'h0);
        check("rst_pc4",  pc_4,              32'h0);

        next_cycle();
        rst_n = 1'b1;

        // First fetch: granted at once, data on the following cycle.
        drive(1, 0, 32'h0, 0, 0, 32'h0);
        check("f1_req",  {31'b0, imem_req}, 32'h1);
        check("f1_addr", imem_addr,         32'h0);
        check("f1_en",   {31'b0, en},       32'h0);
        next_cycle();
        drive(0, 1, 32'h2008_0005, 0, 0, 32'h0);
        check("f1_wait_req", {31'b0, imem_req}, 32'h0);
        check("f1_en_pulse", {31'b0, en},       32'h1);
        check("f1_inst",     inst,              32'h2008_0005);
        check("f1_pc4",      pc_4,              32'h0000_0004);
        next_cycle();
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        check("f2_addr",     imem_addr,         32'h0000_0004);
        check("f2_en_low",   {31'b0, en},       32'h0);
        check("f2_inst_hld", inst,              32'h2008_0005);
        check("f2_req_held", {31'b0, imem_req}, 32'h1);
        next_cycle();
        check("f2_addr_stb", imem_addr,         32'h0000_0004);

        // Load-use stall across delivery: three stalled cycles, then release.
        drive(1, 0, 32'h0, 1, 0, 32'h0);
        check("lu_req_issue", {31'b0, imem_req}, 32'h1);
        next_cycle();
        drive(0, 1, 32'hAC01_0000, 1, 0, 32'h0);
        check("lu_en_c1", {31'b0, en}, 32'h0);
        next_cycle();
        drive(0, 0, 32'hFFFF_FFFF, 1, 0, 32'h0);
        check("lu_en_c2", {31'b0, en}, 32'h0);
        check("lu_inst_c2", inst, 32'h2008_0005);
        next_cycle();
        drive(0, 0, 32'hFFFF_FFFF, 1, 0, 32'h0);
        check("lu_en_c3", {31'b0, en}, 32'h0);
        next_cycle();
        drive(0, 0, 32'hFFFF_FFFF, 0, 0, 32'h0);
        check("lu_en_rel", {31'b0, en}, 32'h1);
        check("lu_inst",   inst,        32'hAC01_0000);
        check("lu_pc4",    pc_4,        32'h0000_0008);
        next_cycle();
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        check("lu_next_addr", imem_addr, 32'h0000_0008);
        check("lu_en_after",  {31'b0, en}, 32'h0);

        // Redirect while waiting; the late response must be dropped.
        drive(1, 0, 32'h0, 0, 0, 32'h0);
        next_cycle();
        drive(0, 0, 32'h0, 0, 1, 32'h0000_0103);
        check("jw_en", {31'b0, en}, 32'h0);
        next_cycle();
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        check("jw_still_wait", {31'b0, imem_req}, 32'h0);
        next_cycle();
        drive(0, 1, 32'hDEAD_BEEF, 0, 0, 32'h0);
        check("jw_drop_en", {31'b0, en}, 32'h0);
        check("jw_drop_inst", inst, 32'hAC01_0000);
        next_cycle();
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        check("jw_addr", imem_addr, 32'h0000_0100);
        check("jw_req",  {31'b0, imem_req}, 32'h1);
        check("jw_en_after", {31'b0, en}, 32'h0);

        // Redirect, stall and rvalid in the same cycle.
        drive(1, 0, 32'h0, 0, 0, 32'h0);
        next_cycle();
        drive(0, 1, 32'h1234_5678, 1, 1, 32'h0000_2007);
        check("jall_en", {31'b0, en}, 32'h0);
        next_cycle();
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        check("jall_addr", imem_addr, 32'h0000_2004);
        check("jall_req",  {31'b0, imem_req}, 32'h1);
        check("jall_inst", inst, 32'hAC01_0000);

        // Redirect in REQ without grant moves the address; then PC wraps on delivery.
        drive(0, 0, 32'h0, 0, 1, 32'hFFFF_FFFF);
        next_cycle();
        drive(1, 0, 32'h0, 0, 0, 32'h0);
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        next_cycle();
        drive(0, 1, 32'h0000_0013, 0, 0, 32'h0);
        check("wrap_en",   {31'b0, en}, 32'h1);
        check("wrap_pc4",  pc_4,        32'h0000_0000);
        check("wrap_inst", inst,        32'h0000_0013);
        next_cycle();
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        check("wrap_next_addr", imem_addr, 32'h0000_0000);

        // Reset asserted while holding a stalled instruction.
        drive(1, 0, 32'h0, 1, 0, 32'h0);
        next_cycle();
        drive(0, 1, 32'h0000_0055, 1, 0, 32'h0);
        next_cycle();
        drive(0, 0, 32'h0, 1, 0, 32'h0);
        check("hold_en", {31'b0, en}, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_req",  {31'b0, imem_req}, 32'h0);
        check("mrst_en",   {31'b0, en},       32'h0);
        check("mrst_inst", inst,              32'h0);
        check("mrst_pc4",  pc_4,              32'h0);
        check("mrst_addr", imem_addr,         32'h0);
        load_use = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        drive(0, 1, 32'h0000_0055, 0, 0, 32'h0);
        check("post_addr",  imem_addr,         32'h0);
        check("post_req",   {31'b0, imem_req}, 32'h1);
        check("post_stale", {31'b0, en},       32'h0);
        next_cycle();
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        check("post_addr2", imem_addr,   32'h0);
        check("post_en2",   {31'b0, en}, 32'h0);
        check("post_inst2", inst,        32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
